// File: rtl/vga_pkg.sv
// Video mode descriptions shared by the raster timing generator and its users.
// A top level picks a mode constant and passes its fields down as parameters.
package vga_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  // 40 MHz pixel clock
  localparam vga_mode_t MODE_800x600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  function automatic int unsigned total(input int unsigned act, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sig_delay.sv
// N-stage shift register that only advances when en_i is high; reset loads rst_val_i
// into every stage so the output starts at a known idle level.
module sig_delay #(
  parameter int unsigned W = 1,
  parameter int unsigned N = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [N-1:0][W-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d[0] = d_i;
      for (int i = 1; i < N; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= {N{rst_val_i}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, region decode, sync/DE
// delayed to match the pixel pipeline, and line/frame event pulses.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = MODE_640x480_60.h_active,
  parameter int unsigned H_FP     = MODE_640x480_60.h_fp,
  parameter int unsigned H_SYNC   = MODE_640x480_60.h_sync,
  parameter int unsigned H_BP     = MODE_640x480_60.h_bp,
  parameter int unsigned V_ACTIVE = MODE_640x480_60.v_active,
  parameter int unsigned V_FP     = MODE_640x480_60.v_fp,
  parameter int unsigned V_SYNC   = MODE_640x480_60.v_sync,
  parameter int unsigned V_BP     = MODE_640x480_60.v_bp,
  parameter bit          HS_POL   = MODE_640x480_60.hs_pol,
  parameter bit          VS_POL   = MODE_640x480_60.vs_pol,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned FC_W     = 16,
  localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HCW     = $clog2(H_TOTAL),
  localparam int unsigned VCW     = $clog2(V_TOTAL)
) (
  input  logic            Clk,
  input  logic            reset_rtl_0,
  input  logic            pix_en,
  output logic [HCW-1:0]  drawX,
  output logic [VCW-1:0]  drawY,
  output logic            active,
  output logic            hsync,
  output logic            vsync,
  output logic            vde,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $fatal(1, "vga_timing_gen: every active/porch/sync parameter must be >= 1");
  end
  if (PIPE_LAT > 8) begin : g_bad_lat
    $fatal(1, "vga_timing_gen: PIPE_LAT must be in 0..8");
  end

  localparam logic [HCW-1:0] XLast   = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] YLast   = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] XActEnd = HCW'(H_ACTIVE);
  localparam logic [VCW-1:0] YActEnd = VCW'(V_ACTIVE);
  localparam logic [HCW-1:0] HsStart = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HsEnd   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] VsStart = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VsEnd   = VCW'(V_ACTIVE + V_FP + V_SYNC);
  // A zero-latency request still costs one register stage.
  localparam int unsigned    DlyN    = (PIPE_LAT == 0) ? 1 : PIPE_LAT;

  logic [HCW-1:0]  x_q, x_d;
  logic [VCW-1:0]  y_q, y_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            run_q, run_d;
  logic            ls_q, ls_d;
  logic            fs_q, fs_d;
  logic            act_raw, hs_raw, vs_raw;
  logic [2:0]      dly_q;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    fc_d  = fc_q;
    run_d = run_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (pix_en) begin
      run_d = 1'b1;
      if (x_q == XLast) begin
        x_d  = '0;
        ls_d = 1'b1;
        if (y_q == YLast) begin
          y_d  = '0;
          fs_d = 1'b1;
          fc_d = fc_q + 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      x_q   <= '0;
      y_q   <= '0;
      fc_q  <= '0;
      run_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      fc_q  <= fc_d;
      run_q <= run_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  // run_q keeps the decode idle while parked at (0,0) out of reset.
  always_comb begin
    act_raw = run_q && (x_q < XActEnd) && (y_q < YActEnd);
    hs_raw  = run_q && (x_q >= HsStart) && (x_q < HsEnd);
    vs_raw  = run_q && (y_q >= VsStart) && (y_q < VsEnd);
  end

  sig_delay #(
    .W (3),
    .N (DlyN)
  ) u_sync_dly (
    .clk_i     (Clk),
    .rst_ni    (reset_rtl_0),
    .en_i      (pix_en),
    .rst_val_i (3'b000),
    .d_i       ({hs_raw, vs_raw, act_raw}),
    .q_o       (dly_q)
  );

  assign drawX       = x_q;
  assign drawY       = y_q;
  assign active      = act_raw;
  assign hsync       = dly_q[2] ~^ HS_POL;
  assign vsync       = dly_q[1] ~^ VS_POL;
  assign vde         = dly_q[0];
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a tiny 15x8 raster (8/2/3/2, 4/1/2/1): instance a uses PIPE_LAT=2 and
// active-low syncs, instance b uses PIPE_LAT=0 and active-high syncs.
module tb_vga_timing_gen;

  logic       Clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [3:0] x_a, x_b;
  logic [2:0] y_a, y_b;
  logic       act_a, hs_a, vs_a, vde_a, ls_a, fs_a;
  logic       act_b, hs_b, vs_b, vde_b, ls_b, fs_b;
  logic [3:0] fc_a, fc_b;

  int checks   = 0;
  int failures = 0;
  int n_fs, n_ls, n_vde, n_hs, n_bad;
  logic en_prev;

  always #5 Clk = ~Clk;

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0), .PIPE_LAT (2), .FC_W (4)
  ) dut_a (
    .Clk (Clk), .reset_rtl_0 (rst_n), .pix_en (pix_en),
    .drawX (x_a), .drawY (y_a), .active (act_a),
    .hsync (hs_a), .vsync (vs_a), .vde (vde_a),
    .line_start (ls_a), .frame_start (fs_a), .frame_count (fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b1), .PIPE_LAT (0), .FC_W (4)
  ) dut_b (
    .Clk (Clk), .reset_rtl_0 (rst_n), .pix_en (pix_en),
    .drawX (x_b), .drawY (y_b), .active (act_b),
    .hsync (hs_b), .vsync (vs_b), .vde (vde_b),
    .line_start (ls_b), .frame_start (fs_b), .frame_count (fc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
    #3;
    chk("rst_async_x", x_a, 0);
    chk("rst_async_hs_a", hs_a, 1);
    step(2);
    chk("rst_x", x_a, 0);
    chk("rst_y", y_a, 0);
    chk("rst_active", act_a, 0);
    chk("rst_hs_a", hs_a, 1);
    chk("rst_vs_a", vs_a, 1);
    chk("rst_vde_a", vde_a, 0);
    chk("rst_hs_b", hs_b, 0);
    chk("rst_vs_b", vs_b, 0);
    chk("rst_ls", ls_a, 0);
    chk("rst_fs", fs_a, 0);
    chk("rst_fc", fc_a, 0);

    // Release; edge k afterwards leaves the raster at x = k % 15, y = k / 15.
    rst_n  = 1'b1;
    pix_en = 1'b1;
    step(1);   // edge 1
    chk("e1_x", x_a, 1);
    chk("e1_active", act_a, 1);
    chk("e1_ls", ls_a, 0);
    step(6);   // edge 7
    chk("e7_active", act_a, 1);
    step(1);   // edge 8
    chk("e8_active", act_a, 0);
    step(2);   // edge 10
    chk("e10_hs_b", hs_b, 0);
    step(1);   // edge 11
    chk("e11_hs_a", hs_a, 1);
    chk("e11_hs_b", hs_b, 1);
    step(1);   // edge 12
    chk("e12_hs_a", hs_a, 0);
    step(1);   // edge 13
    chk("e13_hs_b", hs_b, 1);
    step(1);   // edge 14
    chk("e14_hs_a", hs_a, 0);
    chk("e14_hs_b", hs_b, 0);
    chk("e14_ls", ls_a, 0);
    step(1);   // edge 15
    chk("e15_hs_a", hs_a, 1);
    chk("e15_x", x_a, 0);
    chk("e15_y", y_a, 1);
    chk("e15_ls", ls_a, 1);
    chk("e15_fs", fs_a, 0);
    chk("e15_active", act_a, 1);
    step(1);   // edge 16
    chk("e16_ls", ls_a, 0);
    chk("e16_vde_a", vde_a, 0);
    chk("e16_vde_b", vde_b, 1);
    step(1);   // edge 17
    chk("e17_vde_a", vde_a, 1);
    step(58);  // edge 75
    chk("e75_vs_b", vs_b, 0);
    step(1);   // edge 76
    chk("e76_vs_a", vs_a, 1);
    chk("e76_vs_b", vs_b, 1);
    step(1);   // edge 77
    chk("e77_vs_a", vs_a, 0);
    step(28);  // edge 105
    chk("e105_vs_b", vs_b, 1);
    step(1);   // edge 106
    chk("e106_vs_a", vs_a, 0);
    chk("e106_vs_b", vs_b, 0);
    step(1);   // edge 107
    chk("e107_vs_a", vs_a, 1);
    step(12);  // edge 119
    chk("e119_fs", fs_a, 0);
    chk("e119_fc", fc_a, 0);
    chk("e119_x", x_a, 14);
    chk("e119_y", y_a, 7);
    step(1);   // edge 120
    chk("e120_fs", fs_a, 1);
    chk("e120_ls", ls_a, 1);
    chk("e120_fc", fc_a, 1);
    chk("e120_xy", {x_a, 1'b0, y_a}, 0);
    step(1);   // edge 121
    chk("e121_fs", fs_a, 0);
    chk("e121_fc", fc_a, 1);

    // Idle cycles freeze the counters and the pulses drop after one Clk.
    pix_en = 1'b0;
    step(3);
    chk("idle_x", x_a, 1);
    chk("idle_y", y_a, 0);
    pix_en = 1'b1;
    step(13);
    chk("pre_wrap_x", x_a, 14);
    step(1);
    chk("wrap_ls", ls_a, 1);
    chk("wrap_y", y_a, 1);
    pix_en = 1'b0;
    step(1);
    chk("wrap_ls_width", ls_a, 0);
    chk("wrap_hold_x", x_a, 0);

    // One frame's worth of ticks at 1-of-4 enable, starting from (0,1).
    n_fs = 0; n_ls = 0; n_vde = 0; n_hs = 0; n_bad = 0;
    for (int i = 0; i < 480; i++) begin
      pix_en  = (i % 4 == 0);
      en_prev = pix_en;
      step(1);
      if (en_prev) begin
        if (vde_a) n_vde++;
        if (!hs_a) n_hs++;
        if (fs_a) n_fs++;
        if (ls_a) n_ls++;
      end else if (ls_a || fs_a) begin
        n_bad++;
      end
    end
    chk("slow_fs_count", n_fs, 1);
    chk("slow_ls_count", n_ls, 8);
    chk("slow_vde_ticks", n_vde, 32);
    chk("slow_hs_ticks", n_hs, 24);
    chk("slow_pulse_width", n_bad, 0);
    chk("slow_fc", fc_a, 2);
    chk("slow_x", x_a, 0);
    chk("slow_y", y_a, 1);

    // Asynchronous reset in the middle of a frame.
    pix_en = 1'b1;
    step(40);
    chk("mid_x", x_a, 10);
    chk("mid_y", y_a, 3);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_x", x_a, 0);
    chk("mid_rst_y", y_a, 0);
    chk("mid_rst_active", act_a, 0);
    chk("mid_rst_hs_a", hs_a, 1);
    chk("mid_rst_vs_b", vs_b, 0);
    chk("mid_rst_vde_a", vde_a, 0);
    chk("mid_rst_fc", fc_a, 0);
    step(2);
    rst_n = 1'b1;
    step(119);
    chk("post_rst_fs_early", fs_a, 0);
    chk("post_rst_fc_early", fc_a, 0);
    step(1);
    chk("post_rst_fs", fs_a, 1);
    chk("post_rst_fc", fc_a, 1);
    chk("post_rst_x", x_a, 0);

    // 16 more frames: 17 in total since release, so a 4-bit count wraps to 1.
    n_fs = 1;
    for (int i = 0; i < 16 * 120; i++) begin
      step(1);
      if (fs_a) n_fs++;
    end
    chk("wrap_fs_count", n_fs, 17);
    chk("wrap_fc_a", fc_a, 1);
    chk("wrap_fc_b", fc_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator for the HDMI/VGA output path. Generalises the fixed 640x480@60 timing the current text-mode design relies on.
- Generates pixel/line counters, sync and data-enable signals, and frame/line event pulses.
- Sync/DE outputs are delayed by a configurable pipeline depth, so they stay aligned with pixel data coming from downstream VRAM/font-ROM lookup stages.
- Sits between the clock wizard (pixel clock domain) and the RGB-to-HDMI encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- PIPE_LAT, 2, delay in pix_en ticks applied to hsync/vsync/vde; range 0..8
- FC_W, 16, frame counter width

Ports:
- Clk  in  1  pixel-domain clock
- reset_rtl_0  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel tick; all state advances only when high (tie high for 1:1)
- drawX  out  HCW  current column, undelayed; HCW = $clog2(H_TOTAL)
- drawY  out  VCW  current line, undelayed; VCW = $clog2(V_TOTAL)
- active  out  1  undelayed visible-region flag
- hsync  out  1  delayed horizontal sync, polarity HS_POL
- vsync  out  1  delayed vertical sync, polarity VS_POL
- vde  out  1  delayed data enable
- line_start  out  1  one-Clk pulse when drawX wraps to 0
- frame_start  out  1  one-Clk pulse when drawX = 0 and drawY = 0 are entered
- frame_count  out  FC_W  completed frames, wraps modulo 2^FC_W

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL likewise. Defaults give 800 x 525.
- Reset (async assert, sync deassert handled upstream):
  - drawX = 0, drawY = 0, active = 0
  - hsync = ~HS_POL, vsync = ~VS_POL, vde = 0
  - pulses = 0, frame_count = 0
  - delay-line contents = inactive levels
- Counters, on each Clk with pix_en = 1:
  - drawX increments; at H_TOTAL-1 it wraps to 0 and drawY increments.
  - drawY wraps from V_TOTAL-1 to 0, only at the drawX wrap.
  - pix_en = 0 holds all registers; pulses are forced to 0.
- Region decode (combinational from registered counters):
  - active = (drawX < H_ACTIVE) && (drawY < V_ACTIVE)
  - hs_raw asserted for H_ACTIVE+H_FP <= drawX < H_ACTIVE+H_FP+H_SYNC
  - vs_raw uses the same window on drawY
- Pulses:
  - line_start registered: high for the single Clk in which the counter transitions to drawX = 0.
  - frame_start additionally requires drawY transitioning to 0.
  - Both deassert next Clk regardless of pix_en.
  - Both are suppressed during the first count after reset (they fire only on a wrap, not out of reset).
- frame_count increments in the same Clk that frame_start is registered.
- Delay line:
  - {hs_raw, vs_raw, active} shifts through PIPE_LAT registers, advancing only on pix_en.
  - hsync/vsync/vde are the final stage, with polarity applied at the output.
  - PIPE_LAT = 0: outputs are registered copies with 1-Clk latency; this minimum latency is documented and accepted.
  - PIPE_LAT = N >= 1: outputs lag the raw decode by exactly N pix_en ticks.
- Reset mid-frame: all state returns immediately to reset values; counting restarts at (0,0) on the first pix_en after release.
- Elaboration checks: every porch/sync/active parameter must be >= 1, and PIPE_LAT <= 8. A violation is a $fatal at elaboration.

Decomposition:
- Package vga_pkg:
  - typedef struct vga_mode_t {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol}
  - localparam constants MODE_640x480_60 and MODE_800x600_60 (40 MHz: 800/40/128/88, 600/1/4/23, positive polarity)
  - function total(). Top levels select a mode constant and pass its fields as parameters.
- Sub-module sig_delay #(W, N): an N-stage, enable-gated shift register with a reset value input. Used for the sync/DE alignment and reused by the RGB path.

Test Plan:
- Default mode, pix_en tied high, 2 frames -> hsync low for exactly 96 Clk per line starting at drawX = 656 + 2 lag; 525 lines per frame; 307200 vde-high cycles per frame.
- pix_en toggling 1-of-4 (100 MHz Clk) -> same counts measured in pix_en ticks; registers frozen on idle cycles; pulses 1 Clk wide.
- PIPE_LAT sweep 0, 1, 4, 8 -> vde rising edge trails active rising edge by max(1, N) pix_en ticks; no edge ever misaligned by one.
- 800x600 mode, HS_POL = VS_POL = 1 -> H_TOTAL 1056, V_TOTAL 628; sync high during the sync window; vsync spans 4 lines.
- Assert reset_rtl_0 = 0 at drawX = 300, drawY = 200 -> outputs go to reset values in the same cycle without waiting for Clk; after release, first frame_start occurs after exactly 800*525 ticks; frame_count = 1.
- Preload FC_W = 4, run 17 frames -> frame_count wraps to 1; frame_start count = 17.
